fc_layer_seq: RTL and testbench
===============================

# fc_layer_seq

Sequencer for one fully-connected layer built on a single time-shared multiply-accumulate unit. It replaces one fully parallel dot-product block per output neuron. For each of N_OUT neurons it walks N_IN input/weight pairs from synchronous memories, accumulates the products, adds the neuron's bias, and emits one result per neuron. It sits between the last pooling/flatten stage (input buffer) and the classifier output register file, and is started once per inference.

## Interface
Parameters:
- N_IN, 3136: dot-product length (flattened input count).
- N_OUT, 10: neurons in the layer.
- IN_W, 30: signed input activation width.
- W_W, 9: signed weight and bias width.
- ACC_W, 38: signed accumulator and result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a layer pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- in_addr  out  $clog2(N_IN)  input buffer read address.
- in_data  in  IN_W  signed; valid 1 cycle after in_addr.
- w_addr  out  $clog2(N_IN*N_OUT)  weight ROM address = j*N_IN + k.
- w_data  in  W_W  signed; valid 1 cycle after w_addr.
- b_addr  out  $clog2(N_OUT)  bias ROM address = current neuron j.
- b_data  in  W_W  signed; valid 1 cycle after b_addr.
- out_valid  out  1  one-cycle strobe, one per neuron.
- out_idx  out  $clog2(N_OUT)  neuron index of out_data.
- out_data  out  ACC_W  signed neuron result.
- done  out  1  one-cycle strobe at end of the layer pass.

## Operation
- States: IDLE, MAC, TAIL, BIAS.
- IDLE:
  - All addresses are held at 0.
  - start=1 → clear the accumulator, set j=0 and k=0, go to MAC.
- MAC:
  - Each cycle issues in_addr=k, w_addr=j*N_IN+k, b_addr=j, then k++.
  - From the second MAC cycle onward, acc += in_data*w_data, using the data returned for the previous address.
  - After k=N_IN-1 is issued → TAIL.
- TAIL: accumulate the last product. No address is issued; addresses hold their last value.
- BIAS:
  - out_data <= acc + sext(b_data); out_idx <= j. out_valid is asserted in the following cycle.
  - If j<N_OUT-1: j++, k=0, clear acc, go to MAC.
  - Else go to IDLE. done is asserted together with the final out_valid.
- Arithmetic:
  - Product is the full IN_W+W_W signed width.
  - Product and bias are sign-extended or truncated to ACC_W.
  - The accumulator wraps in two's complement. No saturation, no overflow flag.
- start while busy is ignored.
- start in the same cycle as done returns to IDLE is not accepted; it must be re-asserted.
- rst at any time, mid-pass included:
  - State goes to IDLE; acc, j and k go to 0.
  - No out_valid or done is produced for the aborted pass.
  - The next start runs a complete pass.

## Timing
- Reset values: busy=0, out_valid=0, done=0, out_data=0, out_idx=0, in_addr=0, w_addr=0, b_addr=0.
- start sampled high at cycle 0 → first MAC cycle (k=0 issued) is cycle 1; busy=1 from cycle 1.
- Per neuron: N_IN MAC cycles + 1 TAIL + 1 BIAS = N_IN+2 cycles.
- out_valid for neuron j is high at cycle 1+(j+1)(N_IN+2). It overlaps the first MAC cycle of neuron j+1.
- done is high at cycle 1+N_OUT(N_IN+2), coincident with the last out_valid. busy=0 in that same cycle.
- out_data and out_idx hold their values until the next out_valid or rst.
- Throughput: one MAC per cycle; no stalls. Memories must have fixed 1-cycle read latency.

## Structure
- Package fc_pkg holds:
  - the state enum (IDLE/MAC/TAIL/BIAS);
  - default widths IN_W, W_W, ACC_W;
  - the sign-extend-to-ACC_W function.
- Sub-module fc_mac:
  - registered multiply-accumulate with clr (load 0), en (accumulate product) and add_bias (add sext bias) inputs;
  - ACC_W output.
- The FSM, counters and output registers stay in fc_layer_seq.

## Test plan
- N_IN=4, N_OUT=2, in=[1,2,3,4], w0=[1,1,1,1], b0=5, w1=[-1,0,2,-3], b1=-2, start at cycle 0:
  - out_valid idx0 with data 15 at cycle 7;
  - out_valid idx1 with data -9 at cycle 13, done also at cycle 13;
  - busy high for cycles 1–12.
- Same configuration:
  - in_addr sequence 0,1,2,3 in cycles 1–4 and 7–10;
  - w_addr sequence 0–3 in cycles 1–4, then 4–7 in cycles 7–10;
  - b_addr=1 from cycle 7.
- start pulsed at cycle 3 mid-pass → ignored; out_valid/done timing identical to scenario 1.
- rst asserted at cycle 5 → from cycle 6 all outputs are 0 and state is IDLE; no out_valid. Restart produces 15 and -9 again.
- Overflow: IN_W=30, all in=2^29-1, all w=255, ACC_W=38, N_IN=3136 → out_data equals the two's-complement wrapped sum mod 2^38, matched against the reference model.
- Back-to-back passes: start re-asserted the cycle after done → a second pass gives identical results and timing.

Source files
------------

// File: rtl/fc_layer_seq_pkg.sv
// Shared types, default widths and sign-extension helper for the
// fully-connected layer sequencer.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        TAIL,
        BIAS
    } state_t;

    localparam int unsigned IN_W   = 30;
    localparam int unsigned W_W    = 9;
    localparam int unsigned ACC_W  = 38;
    localparam int unsigned SEXT_W = 64;

    // Replicate bit (width-1) of v into every higher bit; callers then
    // truncate the result to the accumulator width.
    function automatic logic [SEXT_W-1:0] sext_acc(input logic [SEXT_W-1:0] v,
                                                   input int unsigned width);
        logic [SEXT_W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < SEXT_W; i++) begin
            if (i >= width) r[i] = v[width-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Control, memory-read and result bus of the fully-connected layer sequencer.
interface fc_layer_seq_if
    import fc_pkg::*;
#(
    parameter int unsigned N_IN  = 3136,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned IN_W  = fc_pkg::IN_W,
    parameter int unsigned W_W   = fc_pkg::W_W,
    parameter int unsigned ACC_W = fc_pkg::ACC_W
);
    localparam int unsigned IA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int unsigned BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                    start;
    logic                    busy;
    logic [IA_W-1:0]         in_addr;
    logic signed [IN_W-1:0]  in_data;
    logic [WA_W-1:0]         w_addr;
    logic signed [W_W-1:0]   w_data;
    logic [BA_W-1:0]         b_addr;
    logic signed [W_W-1:0]   b_data;
    logic                    out_valid;
    logic [BA_W-1:0]         out_idx;
    logic signed [ACC_W-1:0] out_data;
    logic                    done;

    modport master (
        input  start, in_data, w_data, b_data,
        output busy, in_addr, w_addr, b_addr, out_valid, out_idx, out_data, done
    );

    modport slave (
        output start, in_data, w_data, b_data,
        input  busy, in_addr, w_addr, b_addr, out_valid, out_idx, out_data, done
    );

endinterface

// File: rtl/fc_layer_seq_mac.sv
// Registered multiply-accumulate: clear, accumulate a product, and/or add a
// sign-extended bias, all wrapping in two's complement at ACC_W bits.
module fc_mac
    import fc_pkg::*;
#(
    parameter int unsigned IN_W  = fc_pkg::IN_W,
    parameter int unsigned W_W   = fc_pkg::W_W,
    parameter int unsigned ACC_W = fc_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    add_bias,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic signed [W_W-1:0]   w_data,
    input  logic signed [W_W-1:0]   b_data,
    output logic signed [ACC_W-1:0] acc
);
    localparam int unsigned P_W = IN_W + W_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;

    always_comb begin
        prod   = P_W'(in_data) * P_W'(w_data);
        prod_x = '0;
        bias_x = '0;
        if (en)       prod_x = $signed(ACC_W'(sext_acc(SEXT_W'(unsigned'(prod)), P_W)));
        if (add_bias) bias_x = $signed(ACC_W'(sext_acc(SEXT_W'(unsigned'(b_data)), W_W)));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) acc <= '0;
        else            acc <= acc + prod_x + bias_x;
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: walks N_IN input/weight pairs per neuron
// through one shared MAC, adds the bias and emits one result per neuron.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int unsigned N_IN  = 3136,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned IN_W  = fc_pkg::IN_W,
    parameter int unsigned W_W   = fc_pkg::W_W,
    parameter int unsigned ACC_W = fc_pkg::ACC_W
) (
    input logic            clk,
    input logic            rst,
    fc_layer_seq_if.master bus
);
    localparam int unsigned IA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int unsigned BA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                  state;
    logic                    clr;
    logic                    en;
    logic                    add_bias;
    logic signed [ACC_W-1:0] acc;

    // The bias is folded into the TAIL update (b_data is already valid there),
    // so the accumulator holds the finished neuron value during BIAS.
    always_comb begin
        clr      = (state == IDLE) || (state == BIAS);
        en       = ((state == MAC) && (bus.in_addr != '0)) || (state == TAIL);
        add_bias = (state == TAIL);
    end

    fc_mac #(
        .IN_W (IN_W),
        .W_W  (W_W),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .add_bias(add_bias),
        .in_data (bus.in_data),
        .w_data  (bus.w_data),
        .b_data  (bus.b_data),
        .acc     (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.in_addr   <= '0;
            bus.w_addr    <= '0;
            bus.b_addr    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_data  <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with done must be re-asserted.
                    if (bus.start && !bus.done) begin
                        state    <= MAC;
                        bus.busy <= 1'b1;
                    end
                end
                MAC: begin
                    if (bus.in_addr == IA_W'(N_IN - 1)) begin
                        state <= TAIL;
                    end else begin
                        bus.in_addr <= bus.in_addr + IA_W'(1);
                        bus.w_addr  <= bus.w_addr + WA_W'(1);
                    end
                end
                TAIL: state <= BIAS;
                BIAS: begin
                    bus.out_valid <= 1'b1;
                    bus.out_idx   <= bus.b_addr;
                    bus.out_data  <= acc;
                    if (bus.b_addr == BA_W'(N_OUT - 1)) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.in_addr <= '0;
                        bus.w_addr  <= '0;
                        bus.b_addr  <= '0;
                    end else begin
                        state       <= MAC;
                        bus.in_addr <= '0;
                        bus.w_addr  <= bus.w_addr + WA_W'(1);
                        bus.b_addr  <= bus.b_addr + BA_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: a small 4x2 layer with hand-computed
// results and a full-length 3136x2 layer exercising accumulator wrap.
module tb_fc_layer_seq;

    typedef struct {
        longint idx;
        longint data;
        longint cyc;
        longint dn;
    } exp_t;

    logic   clk;
    logic   rst;
    longint cyc;
    longint t0;
    longint bt0;
    bit     chk_on;
    int     n_vec;
    int     n_err;
    exp_t   sq[$];
    exp_t   bq[$];

    fc_layer_seq_if #(.N_IN(4),    .N_OUT(2), .IN_W(30), .W_W(9), .ACC_W(38)) sif ();
    fc_layer_seq_if #(.N_IN(3136), .N_OUT(2), .IN_W(30), .W_W(9), .ACC_W(38)) bif ();

    fc_layer_seq #(.N_IN(4), .N_OUT(2), .IN_W(30), .W_W(9), .ACC_W(38)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    fc_layer_seq #(.N_IN(3136), .N_OUT(2), .IN_W(30), .W_W(9), .ACC_W(38)) dut_big (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    logic signed [29:0] in_mem[4];
    logic signed [8:0]  w_mem[8];
    logic signed [8:0]  b_mem[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous 1-cycle-latency memories
    always @(posedge clk) begin
        sif.in_data <= in_mem[sif.in_addr];
        sif.w_data  <= w_mem[sif.w_addr];
        sif.b_data  <= b_mem[sif.b_addr];
        bif.in_data <= 30'sd536870911;
        bif.w_data  <= (int'(bif.w_addr) < 3136) ? 9'h0FF : 9'h100;
        bif.b_data  <= (bif.b_addr == 1'b0) ? 9'd100 : 9'h100;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint wrap38(input longint v);
        longint m;
        m = v & ((64'sd1 <<< 38) - 64'sd1);
        if (m >= (64'sd1 <<< 37)) m = m - (64'sd1 <<< 38);
        return m;
    endfunction

    // Small-layer monitor: result scoreboard plus busy/address timing model.
    always @(negedge clk) begin
        if (chk_on) begin
            longint rel, pos, nrn, ex_busy, ex_in, ex_w, ex_b;
            exp_t e;
            if (sif.out_valid) begin
                if (sq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk("out_idx", longint'(sif.out_idx), e.idx);
                    chk("out_data", longint'(sif.out_data), e.data);
                    chk("out_valid_cycle", cyc - t0, e.cyc - t0);
                    chk("done_with_valid", longint'(sif.done), e.dn);
                end
            end else begin
                chk("done_without_valid", longint'(sif.done), 0);
            end
            rel = cyc - t0 - 1;
            ex_busy = 0; ex_in = 0; ex_w = 0; ex_b = 0;
            if (rel >= 0 && rel < 2 * 6) begin
                nrn     = rel / 6;
                pos     = rel % 6;
                if (pos > 3) pos = 3;
                ex_busy = 1;
                ex_in   = pos;
                ex_w    = nrn * 4 + pos;
                ex_b    = nrn;
            end
            chk("busy", longint'(sif.busy), ex_busy);
            chk("in_addr", longint'(sif.in_addr), ex_in);
            chk("w_addr", longint'(sif.w_addr), ex_w);
            chk("b_addr", longint'(sif.b_addr), ex_b);
        end
    end

    // Full-length monitor
    always @(negedge clk) begin
        if (chk_on) begin
            exp_t e;
            if (bif.out_valid) begin
                if (bq.size() == 0) begin
                    chk("big_unexpected_out_valid", 1, 0);
                end else begin
                    e = bq.pop_front();
                    chk("big_out_idx", longint'(bif.out_idx), e.idx);
                    chk("big_out_data", longint'(bif.out_data), e.data);
                    chk("big_out_valid_cycle", cyc - bt0, e.cyc - bt0);
                    chk("big_done_with_valid", longint'(bif.done), e.dn);
                end
            end else begin
                chk("big_done_without_valid", longint'(bif.done), 0);
            end
        end
    end

    task automatic push_small(input longint s);
        sq.push_back('{idx: 0, data: 15, cyc: s + 7,  dn: 0});
        sq.push_back('{idx: 1, data: -9, cyc: s + 13, dn: 1});
    endtask

    task automatic start_small(input bit expect_results);
        @(posedge clk);
        #1;
        sif.start = 1'b1;
        t0 = cyc;
        if (expect_results) push_small(t0);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
    endtask

    task automatic drain_small(input int limit);
        for (int i = 0; i < limit && sq.size() > 0; i++) @(posedge clk);
        if (sq.size() != 0) begin
            chk("small_timeout_pending", longint'(sq.size()), 0);
            sq.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      longint'(sif.busy), 0);
        chk({tag, "_out_valid"}, longint'(sif.out_valid), 0);
        chk({tag, "_done"},      longint'(sif.done), 0);
        chk({tag, "_out_data"},  longint'(sif.out_data), 0);
        chk({tag, "_out_idx"},   longint'(sif.out_idx), 0);
        chk({tag, "_in_addr"},   longint'(sif.in_addr), 0);
        chk({tag, "_w_addr"},    longint'(sif.w_addr), 0);
        chk({tag, "_b_addr"},    longint'(sif.b_addr), 0);
    endtask

    initial begin
        longint a;
        in_mem = '{30'sd1, 30'sd2, 30'sd3, 30'sd4};
        w_mem  = '{9'sd1, 9'sd1, 9'sd1, 9'sd1, -9'sd1, 9'sd0, 9'sd2, -9'sd3};
        b_mem  = '{9'sd5, -9'sd2};
        cyc = 0; t0 = -1000; bt0 = -1000;
        chk_on = 1'b0; n_vec = 0; n_err = 0;
        rst = 1'b1; sif.start = 1'b0; bif.start = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        chk("big_reset_out_data", longint'(bif.out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);

        // Plain pass
        start_small(1'b1);
        drain_small(40);

        // Start pulsed again at cycle 3 is ignored
        start_small(1'b1);
        repeat (2) @(posedge clk);
        #1;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        drain_small(40);

        // Reset at cycle 5 aborts the pass, then a clean restart
        start_small(1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        t0 = -1000;
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        repeat (12) @(posedge clk);
        start_small(1'b1);
        drain_small(40);

        // Back-to-back: start held in the done cycle is ignored, next cycle accepted
        start_small(1'b1);
        repeat (12) @(posedge clk);
        #1;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        push_small(t0);
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        drain_small(60);

        // Full-length pass with accumulator wrap
        a = 536870911;
        @(posedge clk);
        #1;
        bif.start = 1'b1;
        bt0 = cyc;
        bq.push_back('{idx: 0, data: wrap38(a * 255 * 3136 + 100),   cyc: bt0 + 1 + 3138,     dn: 0});
        bq.push_back('{idx: 1, data: wrap38(-(a * 256 * 3136) - 256), cyc: bt0 + 1 + 2 * 3138, dn: 1});
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        for (int i = 0; i < 7000 && bq.size() > 0; i++) @(posedge clk);
        if (bq.size() != 0) begin
            chk("big_timeout_pending", longint'(bq.size()), 0);
            bq.delete();
        end
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
